// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep stage.
// Row bit order: row 000 maps to word bit 7, row 111 to bit 0.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   localparam int N_IN = 3;
   localparam int TT_W = 8;

   function automatic logic [N_IN-1:0] row_bit(
      input logic [N_IN-1:0] idx
   );
      return 3'd7 - idx;
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable settle counter with clear and terminal-count flag.
// Reused by the characterisation stages to time input settling.
module tt_settle_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   // counter: clear wins over load, load wins over count
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/tt_sweep_sampler.sv
// Sweeps a 3-input logic block through all rows and checks its word.
// Define TT_SWEEP_MAJORITY_EN for 3-cycle 2-of-3 majority sampling.
module tt_sweep_sampler
   import tt_sweep_pkg::*;
#(
   parameter int unsigned      SETTLE_CYCLES = 16,
   parameter int unsigned      CNT_W         = 16,
   parameter logic [TT_W-1:0]  EXPECTED      = 8'hD2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic            in1,
   output logic            in2,
   output logic            in3,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] tt_word,
   output logic            pass
);

   if (SETTLE_CYCLES == 0 || (SETTLE_CYCLES >> CNT_W) != 0)
   begin : g_bad_settle
      $error("SETTLE_CYCLES must be 1..2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE_CYCLES - 1);

   state_e          state;
   logic [N_IN-1:0] idx;
   logic [N_IN-1:0] ins;
   logic            tc;
   logic            tmr_clr;
   logic            tmr_en;
   logic            samp_bit;
   logic            samp_last;
   logic [TT_W-1:0] word_nxt;

`ifdef TT_SWEEP_MAJORITY_EN
   logic [1:0] sidx;
   logic [1:0] smp;
`endif

   // sample value and the word it produces for the current row
   always_comb begin
`ifdef TT_SWEEP_MAJORITY_EN
      samp_last = (sidx == 2'd2);
      samp_bit  = (smp[0] & smp[1])
                | (smp[0] & dut_out)
                | (smp[1] & dut_out);
`else
      samp_last = 1'b1;
      samp_bit  = dut_out;
`endif
      word_nxt = tt_word;
      word_nxt[row_bit(idx)] = samp_bit;
   end

   assign tmr_clr = (state == IDLE)
                  || ((state == SAMPLE) && samp_last);
   assign tmr_en  = (state == SETTLE) && !tc;

   tt_settle_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (tmr_en),
      .term     (TERM),
      .tc       (tc)
   );

   // sweep sequencer with registered row drive and results
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         ins     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         tt_word <= '0;
         pass    <= 1'b0;
`ifdef TT_SWEEP_MAJORITY_EN
         sidx    <= 2'd0;
         smp     <= 2'b00;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               ins <= '0;
               if (start) begin
                  idx     <= '0;
                  tt_word <= '0;
                  pass    <= 1'b0;
                  busy    <= 1'b1;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (tc) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
`ifdef TT_SWEEP_MAJORITY_EN
               if (!samp_last) begin
                  smp[sidx[0]] <= dut_out;
                  sidx         <= sidx + 2'd1;
               end else begin
                  sidx <= 2'd0;
               end
`endif
               if (samp_last) begin
                  tt_word <= word_nxt;
                  if (idx == 3'd7) begin
                     pass  <= (word_nxt == EXPECTED);
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 3'd1;
                     ins   <= idx + 3'd1;
                     state <= SETTLE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               ins   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign {in1, in2, in3} = ins;

endmodule

// File: tb/tb_tt_sweep_sampler.sv
// Bench for tt_sweep_sampler: time-based reference model plus directed
// and random stimulus on two instances (SETTLE_CYCLES 4 and 1).
module tb_tt_sweep_sampler;

`ifdef TT_SWEEP_MAJORITY_EN
   localparam int K    = 3;
   localparam int LAT4 = 57;
   localparam int LAT1 = 33;
`else
   localparam int K    = 1;
   localparam int LAT4 = 41;
   localparam int LAT1 = 17;
`endif
   localparam logic [7:0] EXP = 8'hD2;
   localparam int P4 = 4 + K;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start = 1'b0;
   int   mode = 0;
   logic rnd_bit = 1'b0;
   logic glitch = 1'b0;

   logic a1, a2, a3, a_busy, a_done, a_pass, a_dout;
   logic b1, b2, b3, b_busy, b_done, b_pass, b_dout;
   logic [7:0] a_tt, b_tt;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   function automatic logic drv(input int md, input logic rb,
                                input logic [2:0] r);
      logic [7:0] t;
      t = EXP;
      case (md)
         0: return t[3'd7 - r];
         1: return 1'b0;
         2: return 1'b1;
         default: return rb;
      endcase
   endfunction

   assign a_dout = drv(mode, rnd_bit, {a1, a2, a3}) ^ glitch;
   assign b_dout = drv(mode, rnd_bit, {b1, b2, b3});

   tt_sweep_sampler #(
      .SETTLE_CYCLES(4), .CNT_W(16), .EXPECTED(8'hD2)
   ) u4 (
      .clk(clk), .rst(rst), .start(start), .dut_out(a_dout),
      .in1(a1), .in2(a2), .in3(a3), .busy(a_busy),
      .done(a_done), .tt_word(a_tt), .pass(a_pass)
   );

   tt_sweep_sampler #(
      .SETTLE_CYCLES(1), .CNT_W(16), .EXPECTED(8'hD2)
   ) u1 (
      .clk(clk), .rst(rst), .start(start), .dut_out(b_dout),
      .in1(b1), .in2(b2), .in3(b3), .busy(b_busy),
      .done(b_done), .tt_word(b_tt), .pass(b_pass)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   // reference model: position within a sweep is elapsed cycles k
   int   S[2] = '{4, 1};
   bit   act[2] = '{0, 0};
   int   k[2] = '{0, 0};
   logic [7:0] w[2] = '{8'h00, 8'h00};
   bit   ps[2] = '{0, 0};
   int   ones[2] = '{0, 0};

   always @(posedge clk) begin
      logic d [2];
      d[0] = a_dout;
      d[1] = b_dout;
      for (int i = 0; i < 2; i++) begin
         int p, l, ph, r;
         p = S[i] + K;
         l = 8 * p + 1;
         if (rst) begin
            act[i] = 0;
            w[i] = 8'h00;
            ps[i] = 0;
         end else if (!act[i]) begin
            if (start) begin
               act[i] = 1;
               k[i] = 1;
               w[i] = 8'h00;
               ps[i] = 0;
               ones[i] = 0;
            end
         end else begin
            if (k[i] <= 8 * p) begin
               ph = (k[i] - 1) % p;
               r = (k[i] - 1) / p;
               if (ph >= S[i]) begin
                  ones[i] += int'(d[i]);
                  if (ph == p - 1) begin
                     w[i][7 - r] = (K == 1) ? (ones[i] > 0)
                                            : (ones[i] >= 2);
                     ones[i] = 0;
                     if (r == 7) ps[i] = (w[i] == EXP);
                  end
               end
            end
            k[i]++;
            if (k[i] > l) act[i] = 0;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int p, l;
            logic bz, dn, ps_d;
            logic [2:0] iv;
            logic [7:0] tw;
            string nm;
            p = S[i] + K;
            l = 8 * p + 1;
            nm = (i == 0) ? "u4" : "u1";
            bz = (i == 0) ? a_busy : b_busy;
            dn = (i == 0) ? a_done : b_done;
            ps_d = (i == 0) ? a_pass : b_pass;
            iv = (i == 0) ? {a1, a2, a3} : {b1, b2, b3};
            tw = (i == 0) ? a_tt : b_tt;
            chk({nm, " busy"}, 32'(bz), 32'(act[i]));
            chk({nm, " done"}, 32'(dn), 32'(act[i] && k[i] == l));
            if (!act[i])
               chk({nm, " in"}, 32'(iv), 32'd0);
            else if (k[i] <= 8 * p)
               chk({nm, " in"}, 32'(iv), 32'((k[i] - 1) / p));
            chk({nm, " tt_word"}, 32'(tw), 32'(w[i]));
            chk({nm, " pass"}, 32'(ps_d), 32'(ps[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic       s_busy, s_done;
   logic [2:0] s_in;
   logic [7:0] s_tt;

   task automatic sweep(input int rst_at, input int st_at,
                        input int gl_at, output int n4,
                        output int n1, output int nd4);
      n4 = 0;
      n1 = 0;
      nd4 = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= LAT4 + 3; n++) begin
         rst = (n == rst_at);
         start = (n == st_at);
         glitch = (n == gl_at);
         @(negedge clk);
         if (a_done) begin
            if (n4 == 0) n4 = n;
            nd4++;
         end
         if (b_done && n1 == 0) n1 = n;
         if (n == rst_at + 1) begin
            s_busy = a_busy;
            s_done = a_done;
            s_in = {a1, a2, a3};
            s_tt = a_tt;
         end
         step();
      end
      rst = 1'b0;
      start = 1'b0;
      glitch = 1'b0;
   endtask

   initial begin
      int n4, n1, nd4, d1, d2;
      rst = 1'b1;
      step();
      step();
      chk_en = 1'b1;
      rst = 1'b0;
      step();
      chk("reset busy", 32'(a_busy), 32'd0);
      chk("reset done", 32'(a_done), 32'd0);
      chk("reset in", 32'({a1, a2, a3}), 32'd0);
      chk("reset tt_word", 32'(a_tt), 32'h00);
      chk("reset pass", 32'(a_pass), 32'd0);

      mode = 0;
      sweep(0, 0, 0, n4, n1, nd4);
      chk("d2 latency u4", 32'(n4), 32'(LAT4));
      chk("d2 latency u1", 32'(n1), 32'(LAT1));
      chk("d2 done count", 32'(nd4), 32'd1);
      chk("d2 tt_word u4", 32'(a_tt), 32'hD2);
      chk("d2 pass u4", 32'(a_pass), 32'd1);
      chk("d2 tt_word u1", 32'(b_tt), 32'hD2);
      chk("d2 pass u1", 32'(b_pass), 32'd1);
      idle(LAT4 + 3);

      mode = 1;
      sweep(0, 0, 0, n4, n1, nd4);
      chk("stuck0 tt_word", 32'(a_tt), 32'h00);
      chk("stuck0 pass", 32'(a_pass), 32'd0);
      idle(LAT4 + 3);
      mode = 2;
      sweep(0, 0, 0, n4, n1, nd4);
      chk("stuck1 tt_word", 32'(a_tt), 32'hFF);
      chk("stuck1 pass", 32'(a_pass), 32'd0);
      idle(LAT4 + 3);

      mode = 0;
      sweep(3 * P4 + 2, 0, 0, n4, n1, nd4);
      chk("rst busy", 32'(s_busy), 32'd0);
      chk("rst done", 32'(s_done), 32'd0);
      chk("rst in", 32'(s_in), 32'd0);
      chk("rst tt_word", 32'(s_tt), 32'h00);
      chk("rst no done", 32'(nd4), 32'd0);
      idle(LAT4 + 3);
      sweep(0, 0, 0, n4, n1, nd4);
      chk("post-rst latency", 32'(n4), 32'(LAT4));
      chk("post-rst tt_word", 32'(a_tt), 32'hD2);
      idle(LAT4 + 3);

      sweep(0, 5 * P4 + 2, 0, n4, n1, nd4);
      chk("repulse latency", 32'(n4), 32'(LAT4));
      chk("repulse done count", 32'(nd4), 32'd1);
      idle(LAT4 + 3);

      start = 1'b1;
      d1 = 0;
      d2 = 0;
      nd4 = 0;
      step();
      for (int n = 1; n <= 2 * LAT4 + 2; n++) begin
         if (n == 2 * LAT4 + 2) start = 1'b0;
         @(negedge clk);
         if (a_done) begin
            nd4++;
            if (d1 == 0) d1 = n;
            else d2 = n;
         end
         step();
      end
      start = 1'b0;
      chk("held done count", 32'(nd4), 32'd2);
      chk("held first done", 32'(d1), 32'(LAT4));
      chk("held second done", 32'(d2), 32'(2 * LAT4 + 1));
      idle(LAT4 + 3);

`ifdef TT_SWEEP_MAJORITY_EN
      mode = 0;
      sweep(0, 0, 4 + 2, n4, n1, nd4);
      chk("glitch latency", 32'(n4), 32'd57);
      chk("glitch tt_word", 32'(a_tt), 32'hD2);
      chk("glitch pass", 32'(a_pass), 32'd1);
      idle(LAT4 + 3);
`endif

      mode = 3;
      for (int n = 0; n < 4000; n++) begin
         rnd_bit = 1'($urandom);
         start = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      start = 1'b0;
      rst = 1'b0;
      idle(LAT4 + 5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
